// File: rtl/productos_pkg.sv
// Shared definitions for the product checker: status codes, price table,
// word-width derivation, close-out FSM states and the result record layout.
package productos_pkg;

  // Expiry / assignment status carried with every decoded word
  localparam logic [1:0] V_NO_ASIGNADO = 2'b00;
  localparam logic [1:0] V_VALIDO      = 2'b01;
  localparam logic [1:0] V_HOY         = 2'b10;
  localparam logic [1:0] V_CADUCADO    = 2'b11;

  // A scanned word is {dia[4:0], mes[3:0], code}
  localparam int FECHA_W        = 9;
  localparam int PRECIO_TABLA_W = 4;

  // Default widths of the block, used for the reference result layout
  localparam int DEF_CODE_W  = 3;
  localparam int DEF_PRICE_W = 4;
  localparam int DEF_LW      = FECHA_W + DEF_CODE_W;

  function automatic int ancho_palabra(input int code_w);
    return FECHA_W + code_w;
  endfunction

  typedef struct packed {
    logic                      asignado;
    logic [PRECIO_TABLA_W-1:0] precio;
  } entrada_tabla_t;

  // Price list of the shop: only a handful of codes are sold
  function automatic entrada_tabla_t tabla_precios(input int unsigned code);
    entrada_tabla_t e;
    e.asignado = 1'b0;
    e.precio   = '0;
    case (code)
      32'd1: begin e.asignado = 1'b1; e.precio = 4'd4;  end
      32'd2: begin e.asignado = 1'b1; e.precio = 4'd10; end
      32'd5: begin e.asignado = 1'b1; e.precio = 4'd15; end
      default: ;
    endcase
    return e;
  endfunction

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    DONE
  } estado_t;

  // Result record at the default widths; the top builds the same layout
  // at whatever widths it is parametrised with.
  typedef struct packed {
    logic [DEF_PRICE_W-1:0] P;
    logic [1:0]             V;
    logic [DEF_LW-1:0]      QR;
  } resultado_t;

endpackage

// File: rtl/fifo_sinc.sv
// Synchronous FIFO with occupancy count; storage is cleared by clr so the
// head reads as zero straight after reset.
module fifo_sinc #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             push_ok, pop_ok;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign pop_ok  = pop & ~empty;
  // A full FIFO still takes a word when the head leaves on the same edge
  assign push_ok = push & (~full | pop_ok);
  assign rdata   = mem_q[rd_q];
  assign count   = cnt_q;

  // Pointer and occupancy next-state; pointers wrap since DEPTH is a power of two
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push_ok) wr_d = wr_q + AW'(1);
    if (pop_ok)  rd_d = rd_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage array
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push_ok) begin
      mem_q[wr_q] <= wdata;
    end
  end

endmodule

// File: rtl/verificador_productos.sv
// Streaming product checker: decodes scanned words into price and expiry
// status, queues the results, keeps sales/expired totals and runs close-out.
module verificador_productos
  import productos_pkg::*;
#(
  parameter int CODE_W  = 3,
  parameter int DEPTH   = 4,
  parameter int PRICE_W = 4,
  parameter int TOTAL_W = 12,
  parameter int CNT_W   = 8,
  localparam int LW = ancho_palabra(CODE_W)
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               en,
  input  logic [4:0]         dia_ref,
  input  logic [3:0]         mes_ref,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [LW-1:0]      L,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PRICE_W-1:0] P,
  output logic [1:0]         V,
  output logic [LW-1:0]      QR,
  output logic [TOTAL_W-1:0] total,
  output logic [CNT_W-1:0]   n_cad,
  input  logic               cerrar,
  output logic               hecho
);

  localparam int OCC_W = $clog2(DEPTH) + 1;
  localparam logic [OCC_W:0] DEPTH_L = (OCC_W + 1)'(DEPTH);
  localparam int SUM_W = TOTAL_W + 1;

  typedef struct packed {
    logic [PRICE_W-1:0] P;
    logic [1:0]         V;
    logic [LW-1:0]      QR;
  } resultado_w_t;

  logic [4:0]        dia;
  logic [3:0]        mes;
  logic [CODE_W-1:0] code;
  entrada_tabla_t    tabla;
  resultado_w_t      dec;

  resultado_w_t      stage_q, stage_d;
  logic              stage_valid_q, stage_valid_d;
  logic              arrancado_q, arrancado_d;
  estado_t           estado_q, estado_d;
  logic [TOTAL_W-1:0] total_q, total_d;
  logic [CNT_W-1:0]  n_cad_q, n_cad_d;

  resultado_w_t      head;
  logic              fifo_full, fifo_empty;
  logic [OCC_W-1:0]  fifo_count;
  logic [OCC_W:0]    ocupacion;
  logic [TOTAL_W:0]  suma;
  logic              accept, pop;

  assign dia   = L[LW-1 -: 5];
  assign mes   = L[CODE_W +: 4];
  assign code  = L[CODE_W-1:0];
  assign tabla = tabla_precios(32'(code));

  // Word decode: unassigned codes never carry a price or a date verdict,
  // impossible dates on sold products count as expired
  always_comb begin
    dec    = '0;
    dec.V  = V_NO_ASIGNADO;
    dec.QR = L;
    if (tabla.asignado) begin
      dec.P = PRICE_W'(tabla.precio);
      if (dia == 5'd0 || mes == 4'd0 || mes > 4'd12) begin
        dec.V = V_CADUCADO;
      end else if ({mes, dia} > {mes_ref, dia_ref}) begin
        dec.V = V_VALIDO;
      end else if ({mes, dia} == {mes_ref, dia_ref}) begin
        dec.V = V_HOY;
      end else begin
        dec.V = V_CADUCADO;
      end
    end
  end

  // Stage and FIFO together never hold more than DEPTH words, so the stage
  // always finds room in the FIFO on the following edge
  assign ocupacion = {1'b0, fifo_count} + {{OCC_W{1'b0}}, stage_valid_q};
  assign in_ready  = en & arrancado_q & (estado_q == RUN) & ~fifo_full
                     & (ocupacion < DEPTH_L);
  assign accept    = in_valid & in_ready;
  assign out_valid = ~fifo_empty;
  assign pop       = out_valid & out_ready;

  // Stage next-state: load on accept, otherwise the slot empties into the FIFO
  always_comb begin
    stage_d       = stage_q;
    stage_valid_d = accept;
    arrancado_d   = 1'b1;
    if (accept) stage_d = dec;
  end

  // Stage register and the start-up flag that keeps in_ready low until the first edge
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      stage_q       <= '0;
      stage_valid_q <= 1'b0;
      arrancado_q   <= 1'b0;
    end else begin
      stage_q       <= stage_d;
      stage_valid_q <= stage_valid_d;
      arrancado_q   <= arrancado_d;
    end
  end

  fifo_sinc #(
    .WIDTH ($bits(resultado_w_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .clr   (clr),
    .push  (stage_valid_q),
    .wdata (stage_q),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign P  = head.P;
  assign V  = head.V;
  assign QR = head.QR;

  assign suma = {1'b0, total_q} + SUM_W'(head.P);

  // Totals follow popped entries and pin at all-ones; a close-out
  // acknowledgement in DONE starts a fresh session
  always_comb begin
    total_d = total_q;
    n_cad_d = n_cad_q;
    if (estado_q == DONE && cerrar) begin
      total_d = '0;
      n_cad_d = '0;
    end else if (pop) begin
      if (head.V == V_VALIDO || head.V == V_HOY) begin
        total_d = suma[TOTAL_W] ? '1 : suma[TOTAL_W-1:0];
      end else if (head.V == V_CADUCADO && n_cad_q != '1) begin
        n_cad_d = n_cad_q + CNT_W'(1);
      end
    end
  end

  // Totals registers
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      total_q <= '0;
      n_cad_q <= '0;
    end else begin
      total_q <= total_d;
      n_cad_q <= n_cad_d;
    end
  end

  assign total = total_q;
  assign n_cad = n_cad_q;

  // Close-out state register
  always_ff @(posedge clk or posedge clr) begin
    if (clr) estado_q <= RUN;
    else     estado_q <= estado_d;
  end

  // Close-out sequencing: stop intake, wait for stage and FIFO to empty, then hold
  always_comb begin
    estado_d = estado_q;
    hecho    = 1'b0;
    case (estado_q)
      RUN:   if (cerrar) estado_d = DRAIN;
      DRAIN: if (!stage_valid_q && fifo_empty) estado_d = DONE;
      DONE: begin
        hecho = 1'b1;
        if (cerrar) estado_d = RUN;
      end
      default: estado_d = RUN;
    endcase
  end

endmodule

// File: doc/verificador_productos.md
# verificador_productos

Parametrised, streaming successor of the single-word product checker. It accepts scanned product words {day, month, code} through a valid/ready handshake and decodes each word into a price and an expiry status against a reference date. Results are buffered in a DEPTH-entry FIFO, and the block accumulates a running sales total and an expired-item count. A close-out state machine drains the pipeline and freezes the totals. The block sits between the scanner front end and the till/display logic.

## Interface
- CODE_W, 3: product-code width; input word width LW = 9 + CODE_W.
- DEPTH, 4: result FIFO depth (≥2, power of two).
- PRICE_W, 4: price width.
- TOTAL_W, 12: sales-total accumulator width.
- CNT_W, 8: expired-item counter width.

Ports:
- clk  in  1  single clock, rising edge.
- clr  in  1  reset, asynchronous, active-high.
- en  in  1  input enable; 0 forces in_ready=0 and leaves the output side running.
- dia_ref  in  5  reference day.
- mes_ref  in  4  reference month.
- in_valid  in  1  L is valid.
- in_ready  out  1  block accepts L this cycle.
- L  in  LW  {dia[4:0], mes[3:0], code[CODE_W-1:0]}.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer takes the head.
- P  out  PRICE_W  price of the head entry.
- V  out  2  status of the head entry: 00 not assigned, 01 valid, 10 expires today, 11 expired.
- QR  out  LW  the original word of the head entry, echoed.
- total  out  TOTAL_W  saturating sum of P over popped entries with V ∈ {01, 10}.
- n_cad  out  CNT_W  saturating count of popped entries with V = 11.
- cerrar  in  1  close-out request pulse.
- hecho  out  1  close-out complete.

## Operation
- Decode, stage 1 register:
  - Price comes from the package table: code 1 → 4, code 2 → 10, code 5 → 15, all other codes → 0 and "not assigned".
  - Date key {mes, dia} is compared with {mes_ref, dia_ref}: greater → 01, equal → 10, less → 11.
  - An unassigned code always yields V=00 and P=0, whatever the date.
  - An assigned code with dia=0, mes=0 or mes>12 yields V=11.
- Accept (in_valid & in_ready): the decoded {P, V, QR} is loaded into the stage register. On the next edge the stage entry is written into the FIFO.
- in_ready = en & (state==RUN) & (FIFO occupancy + stage-valid < DEPTH). No loss, no duplication.
- Pop (out_valid & out_ready): the head is removed and total/n_cad update on the same edge. Both counters saturate at all-ones and never wrap.
- FSM states, reset state RUN:
  - RUN: cerrar → DRAIN. A word accepted in the same cycle as cerrar is still processed.
  - DRAIN: in_ready=0; when the stage and FIFO are both empty → DONE.
  - DONE: hecho=1; totals are frozen and valid. cerrar → clear total and n_cad, go to RUN.
- cerrar in DRAIN is ignored.
- A full FIFO with out_ready=0 holds indefinitely. A simultaneous push and pop on a full FIFO is permitted: occupancy is unchanged.

## Timing
- Reset values: in_ready=0 during clr and 1 from the first edge after release when en=1; out_valid=0; P=0; V=00; QR=0; total=0; n_cad=0; hecho=0; FIFO empty; stage empty; state RUN.
- Latency: a word accepted at edge N is visible at the outputs (out_valid=1) after edge N+1 when the FIFO was empty.
- Throughput: one word per cycle while out_ready=1.
- P, V and QR are driven from FIFO storage and are stable while out_valid=1 and out_ready=0.
- Asserting clr mid-operation, in any state, discards all entries and returns every output to its reset value asynchronously.
- hecho rises one cycle after the last pop that empties the block in DRAIN.
- hecho falls on the edge that sees cerrar in DONE.

## Structure
- Package productos_pkg holds:
  - the V encoding constants;
  - the price/assignment table function indexed by code;
  - the LW derivation;
  - the FSM state typedef (RUN, DRAIN, DONE);
  - the result struct {P, V, QR}.
- One sub-module, fifo_sinc: parametrised synchronous FIFO (width, depth) with full/empty/occupancy outputs and async active-high clr. All decode, stage, accumulator and FSM logic stays in the top module.

## Test plan
- Reference date 25/02. Push 111111100010, 110010010101, 110100010001, 000000000111 with out_ready=1 → (P,V) = (10,01), (15,10), (4,01), (0,00), each 2 cycles after acceptance; total=29, n_cad=0.
- Push an assigned code with date 24/02 (code 1), then code 2 with mes=13 → both give V=11; n_cad=2 and total unchanged.
- Set out_ready=0 and push 5 words with DEPTH=4 → in_ready drops after the 4th accept and the 5th is held. Raise out_ready → all 5 emerge in order, with no loss or duplication.
- Set TOTAL_W=5 and pop 3× Huevos 25/02 → total reads 15, 30, then saturates at 31.
- Pulse cerrar while 3 entries are queued → in_ready=0, hecho=1 one cycle after the last pop, and totals hold. A second cerrar → totals clear and the block returns to RUN.
- Assert clr during DRAIN with 2 entries queued → out_valid=0, totals 0, state RUN, and in_ready=1 after release.
